// File: rtl/b_bus_mux_pipe_pkg.sv
// Shared constants for the registered B-bus source multiplexer: select codes,
// default widths and the skid-buffer occupancy encoding.
package b_bus_pkg;

  localparam int DATA_W_DEF   = 24;
  localparam int NUM_SRC_DEF  = 9;
  localparam int SEL_W_DEF    = 4;
  localparam int NARROW_W_DEF = 8;
  localparam int CNT_W_DEF    = 16;
  localparam logic [NUM_SRC_DEF-1:0] NARROW_MASK_DEF = 9'b000000111;

  // Select codes as issued by the control unit; code k drives source k-1
  localparam logic [SEL_W_DEF-1:0] SEL_ZERO = 4'd0;
  localparam logic [SEL_W_DEF-1:0] SEL_MDR  = 4'd1;
  localparam logic [SEL_W_DEF-1:0] SEL_PC   = 4'd2;
  localparam logic [SEL_W_DEF-1:0] SEL_MBRU = 4'd3;
  localparam logic [SEL_W_DEF-1:0] SEL_L    = 4'd4;
  localparam logic [SEL_W_DEF-1:0] SEL_C1   = 4'd5;
  localparam logic [SEL_W_DEF-1:0] SEL_C2   = 4'd6;
  localparam logic [SEL_W_DEF-1:0] SEL_C3   = 4'd7;
  localparam logic [SEL_W_DEF-1:0] SEL_T    = 4'd8;
  localparam logic [SEL_W_DEF-1:0] SEL_E    = 4'd9;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/b_bus_mux_pipe_if.sv
// Select-request and B-bus output bundle; master is the control unit / ALU side,
// slave is the multiplexer pipeline.
interface b_bus_mux_pipe_if #(
  parameter int DATA_W  = 24,
  parameter int NUM_SRC = 9,
  parameter int SEL_W   = 4,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [SEL_W-1:0]          sel;
  logic                      sel_valid;
  logic                      sel_ready;
  logic [DATA_W-1:0]         b_bus;
  logic                      b_valid;
  logic                      b_ready;
  logic                      err_sel;
  logic                      err_clr;
  logic [CNT_W-1:0]          xfer_cnt;

  modport master (
    output src_data, sel, sel_valid, b_ready, err_clr,
    input  sel_ready, b_bus, b_valid, err_sel, xfer_cnt
  );

  modport slave (
    input  src_data, sel, sel_valid, b_ready, err_clr,
    output sel_ready, b_bus, b_valid, err_sel, xfer_cnt
  );
endinterface

// File: rtl/b_bus_mux_pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. in_ready is registered so the
// consumer's ready never reaches the producer combinationally.
module b_bus_skid_buf
  import b_bus_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  occ_e             state_reg;
  logic [WIDTH-1:0] main_reg;
  logic [WIDTH-1:0] skid_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             accept;
  logic             drain;

  assign accept = in_valid & in_ready_reg;
  assign drain  = out_valid_reg & out_ready;

  // main_reg is always the head; skid_reg only holds the second entry when FULL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      main_reg      <= '0;
      skid_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            main_reg      <= in_data;
            state_reg     <= ONE;
            out_valid_reg <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            skid_reg     <= in_data;
            state_reg    <= FULL;
            in_ready_reg <= 1'b0;
          end else if (drain && !accept) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
          end else if (accept && drain) begin
            main_reg <= in_data;
          end
        end
        FULL: begin
          if (drain) begin
            main_reg     <= skid_reg;
            state_reg    <= ONE;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_data  = main_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: rtl/b_bus_mux_pipe.sv
// Registered B-bus source multiplexer: selects and zero-extends a source,
// queues it in a skid buffer, flags illegal selects and counts transfers.
module b_bus_mux_pipe
  import b_bus_pkg::*;
#(
  parameter int                 DATA_W      = DATA_W_DEF,
  parameter int                 NUM_SRC     = NUM_SRC_DEF,
  parameter int                 SEL_W       = SEL_W_DEF,
  parameter int                 NARROW_W    = NARROW_W_DEF,
  parameter logic [NUM_SRC-1:0] NARROW_MASK = NARROW_MASK_DEF,
  parameter int                 CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  b_bus_mux_pipe_if.slave   bus
);

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_SRC);

  logic [DATA_W-1:0] ext_src [NUM_SRC];
  logic [DATA_W-1:0] sel_value;
  logic              sel_illegal;
  logic              accept;
  logic              drain;
  logic              err_sel_reg;
  logic [CNT_W-1:0]  xfer_cnt_reg;

  // Narrow sources keep only their low byte; the rest of the slice is ignored
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    if (NARROW_MASK[gi]) begin : g_narrow
      assign ext_src[gi] = {{(DATA_W-NARROW_W){1'b0}},
                            bus.src_data[gi*DATA_W +: NARROW_W]};
    end else begin : g_wide
      assign ext_src[gi] = bus.src_data[gi*DATA_W +: DATA_W];
    end
  end

  // Code 0 and out-of-range codes both fall through to the zero bus
  always_comb begin
    sel_value = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.sel == SEL_W'(i + 1)) begin
        sel_value = ext_src[i];
      end
    end
  end

  assign sel_illegal = (bus.sel > MAX_SEL);
  assign accept      = bus.sel_valid & bus.sel_ready;
  assign drain       = bus.b_valid & bus.b_ready;

  b_bus_skid_buf #(
    .WIDTH (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (sel_value),
    .in_valid  (bus.sel_valid),
    .in_ready  (bus.sel_ready),
    .out_data  (bus.b_bus),
    .out_valid (bus.b_valid),
    .out_ready (bus.b_ready)
  );

  // A fresh illegal accept outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel_reg <= 1'b0;
    end else if (accept && sel_illegal) begin
      err_sel_reg <= 1'b1;
    end else if (bus.err_clr) begin
      err_sel_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_reg <= '0;
    end else if (drain) begin
      xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
    end
  end

  assign bus.err_sel  = err_sel_reg;
  assign bus.xfer_cnt = xfer_cnt_reg;

endmodule

// File: tb/tb_b_bus_mux_pipe.sv
// Self-checking bench for b_bus_mux_pipe: vector table, directed corner cases
// and random traffic against a FIFO-level reference model.
module tb_b_bus_mux_pipe;

  localparam int DW = 24;
  localparam int NS = 9;
  localparam int SW = 4;
  localparam int CW = 4;

  logic clk;
  logic rst_n;

  b_bus_mux_pipe_if #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .CNT_W(CW)) bus_if ();

  b_bus_mux_pipe #(
    .DATA_W (DW), .NUM_SRC (NS), .SEL_W (SW), .NARROW_W (8),
    .NARROW_MASK (9'b000000111), .CNT_W (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain 2-deep FIFO of expected values
  logic [DW-1:0] mq[$];
  logic          m_err;
  logic [CW-1:0] m_cnt;

  typedef struct {
    logic [3:0]  sel;
    logic [23:0] exp_val;
    logic        exp_err;
  } vec_t;
  vec_t vecs[16];
  logic [23:0] src_tab[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_val(input logic [3:0] s, input logic [NS*DW-1:0] src);
    logic [DW-1:0] w;
    if (s == 0 || s > 9) return '0;
    w = src[(int'(s) - 1) * DW +: DW];
    if (s <= 3) w = {16'h0, w[7:0]};
    return w;
  endfunction

  task automatic set_src(input int i, input logic [DW-1:0] v);
    bus_if.src_data[i*DW +: DW] = v;
  endtask

  task automatic check_model();
    chk("b_valid", {31'b0, bus_if.b_valid}, {31'b0, mq.size() > 0});
    chk("sel_ready", {31'b0, bus_if.sel_ready}, {31'b0, mq.size() < 2});
    if (mq.size() > 0) chk("b_bus", {8'b0, bus_if.b_bus}, {8'b0, mq[0]});
    chk("err_sel", {31'b0, bus_if.err_sel}, {31'b0, m_err});
    chk("xfer_cnt", {28'b0, bus_if.xfer_cnt}, {28'b0, m_cnt});
  endtask

  // One clock: predict from pre-edge inputs, advance model, compare after edge
  task automatic cycle();
    logic acc, drn;
    logic [DW-1:0] v;
    acc = bus_if.sel_valid && (mq.size() < 2);
    drn = (mq.size() > 0) && bus_if.b_ready;
    v   = ref_val(bus_if.sel, bus_if.src_data);
    @(posedge clk);
    if (drn) void'(mq.pop_front());
    if (acc) mq.push_back(v);
    if (acc && bus_if.sel > 9) m_err = 1'b1;
    else if (bus_if.err_clr) m_err = 1'b0;
    if (drn) m_cnt = m_cnt + 1'b1;
    #1;
    check_model();
  endtask

  task automatic model_reset();
    mq.delete();
    m_err = 1'b0;
    m_cnt = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_b_valid", {31'b0, bus_if.b_valid}, 32'd0);
    chk("rst_sel_ready", {31'b0, bus_if.sel_ready}, 32'd1);
    chk("rst_b_bus", {8'b0, bus_if.b_bus}, 32'd0);
    chk("rst_xfer_cnt", {28'b0, bus_if.xfer_cnt}, 32'd0);
    chk("rst_err_sel", {31'b0, bus_if.err_sel}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    src_tab = '{24'hABCD5A, 24'h7788C3, 24'hFFFF01, 24'h123456, 24'h111111,
                24'hA5A5A5, 24'h0F0F0F, 24'h800001, 24'h00FFEE};
    vecs[0]  = '{4'd0,  24'h000000, 1'b0};
    vecs[1]  = '{4'd1,  24'h00005A, 1'b0};
    vecs[2]  = '{4'd2,  24'h0000C3, 1'b0};
    vecs[3]  = '{4'd3,  24'h000001, 1'b0};
    vecs[4]  = '{4'd4,  24'h123456, 1'b0};
    vecs[5]  = '{4'd5,  24'h111111, 1'b0};
    vecs[6]  = '{4'd6,  24'hA5A5A5, 1'b0};
    vecs[7]  = '{4'd7,  24'h0F0F0F, 1'b0};
    vecs[8]  = '{4'd8,  24'h800001, 1'b0};
    vecs[9]  = '{4'd9,  24'h00FFEE, 1'b0};
    for (int i = 10; i < 16; i++) vecs[i] = '{4'(i), 24'h000000, 1'b1};

    bus_if.src_data  = '0;
    bus_if.sel       = '0;
    bus_if.sel_valid = 1'b0;
    bus_if.b_ready   = 1'b0;
    bus_if.err_clr   = 1'b0;
    do_reset();
    repeat (2) cycle();

    // Narrow zero-extend with one drain
    set_src(0, 24'hABCD5A);
    bus_if.sel = 4'd1; bus_if.sel_valid = 1'b1; bus_if.b_ready = 1'b1;
    cycle();
    chk("mdr_zext", {8'b0, bus_if.b_bus}, 32'h00005A);
    chk("mdr_valid", {31'b0, bus_if.b_valid}, 32'd1);
    bus_if.sel_valid = 1'b0;
    cycle();
    chk("mdr_cnt", {28'b0, bus_if.xfer_cnt}, 32'd1);

    // Vector table: every select code, clear requested alongside each accept
    for (int i = 0; i < 9; i++) set_src(i, src_tab[i]);
    bus_if.b_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_if.sel = vecs[i].sel; bus_if.sel_valid = 1'b1; bus_if.err_clr = 1'b1;
      cycle();
      chk("vec_bus", {8'b0, bus_if.b_bus}, {8'b0, vecs[i].exp_val});
      chk("vec_err", {31'b0, bus_if.err_sel}, {31'b0, vecs[i].exp_err});
    end
    bus_if.sel_valid = 1'b0; bus_if.err_clr = 1'b1;
    repeat (2) cycle();
    bus_if.err_clr = 1'b0;

    // Stall and fill, third request held off
    bus_if.b_ready = 1'b0;
    set_src(3, 24'h123456); set_src(8, 24'h00FFEE);
    bus_if.sel = 4'd4; bus_if.sel_valid = 1'b1; cycle();
    bus_if.sel = 4'd9; cycle();
    chk("fill_ready", {31'b0, bus_if.sel_ready}, 32'd0);
    bus_if.sel = 4'd1; repeat (2) cycle();
    chk("fill_head", {8'b0, bus_if.b_bus}, 32'h123456);
    bus_if.sel_valid = 1'b0; bus_if.b_ready = 1'b1;
    cycle();
    chk("fill_second", {8'b0, bus_if.b_bus}, 32'h00FFEE);
    chk("fill_ready_back", {31'b0, bus_if.sel_ready}, 32'd1);
    cycle();

    // Snapshot: source change after accept must not leak into the stored value
    bus_if.b_ready = 1'b0;
    set_src(4, 24'h111111);
    bus_if.sel = 4'd5; bus_if.sel_valid = 1'b1; cycle();
    bus_if.sel_valid = 1'b0; set_src(4, 24'h222222);
    repeat (2) cycle();
    chk("snapshot", {8'b0, bus_if.b_bus}, 32'h111111);
    bus_if.b_ready = 1'b1; cycle();

    // Illegal select: sticky, set beats clear, clear alone drops it
    bus_if.sel = 4'hF; bus_if.sel_valid = 1'b1; cycle();
    chk("ill_bus", {8'b0, bus_if.b_bus}, 32'd0);
    chk("ill_err", {31'b0, bus_if.err_sel}, 32'd1);
    bus_if.sel_valid = 1'b0; repeat (3) cycle();
    chk("ill_sticky", {31'b0, bus_if.err_sel}, 32'd1);
    bus_if.sel_valid = 1'b1; bus_if.err_clr = 1'b1; cycle();
    chk("ill_set_wins", {31'b0, bus_if.err_sel}, 32'd1);
    bus_if.sel_valid = 1'b0; cycle();
    chk("ill_cleared", {31'b0, bus_if.err_sel}, 32'd0);
    bus_if.err_clr = 1'b0;
    // Illegal select presented while FULL is not accepted
    bus_if.b_ready = 1'b0; bus_if.sel = 4'd2; bus_if.sel_valid = 1'b1;
    repeat (2) cycle();
    bus_if.sel = 4'hE; repeat (2) cycle();
    chk("ill_not_acc", {31'b0, bus_if.err_sel}, 32'd0);
    bus_if.sel_valid = 1'b0; bus_if.b_ready = 1'b1; repeat (3) cycle();

    // Counter wrap: 17 transfers on a 4-bit counter
    do_reset();
    bus_if.sel = 4'd6; bus_if.sel_valid = 1'b1; bus_if.b_ready = 1'b1;
    repeat (18) cycle();
    chk("cnt_wrap", {28'b0, bus_if.xfer_cnt}, 32'd1);

    // Asynchronous reset while FULL
    bus_if.b_ready = 1'b0; repeat (2) cycle();
    chk("pre_rst_full", {31'b0, bus_if.sel_ready}, 32'd0);
    bus_if.sel_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_b_valid", {31'b0, bus_if.b_valid}, 32'd0);
    chk("arst_sel_ready", {31'b0, bus_if.sel_ready}, 32'd1);
    chk("arst_cnt", {28'b0, bus_if.xfer_cnt}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NS; i++) set_src(i, DW'($urandom));
      bus_if.sel       = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                     : 4'($urandom_range(0, 9));
      bus_if.sel_valid = $urandom_range(0, 3) != 0;
      bus_if.b_ready   = $urandom_range(0, 2) != 0;
      bus_if.err_clr   = $urandom_range(0, 5) == 0;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/b_bus_mux_pipe.md
Name: b_bus_mux_pipe

Overview:
- Parametrised, registered successor to the datapath B-bus source multiplexer.
- Selects one of NUM_SRC register sources, zero-extends narrow (8-bit) sources, and snapshots the result into a 2-entry skid buffer.
- Uses a valid/ready handshake so the control unit can issue a select while the ALU stalls.
- Flags illegal selects and counts completed bus transfers.

Parameters:
- DATA_W, 24, B-bus width in bits.
- NUM_SRC, 9, number of bus sources; select code k (1..NUM_SRC) picks source k-1.
- SEL_W, 4, select width; must satisfy 2**SEL_W > NUM_SRC.
- NARROW_W, 8, width of narrow sources (MDR/PC/MBRU class).
- NARROW_MASK, 9'b000000111, bit i set means source i is narrow. Bits [NARROW_W-1:0] are taken and zero-extended to DATA_W.
- CNT_W, 16, transfer counter width.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- src_data, input, NUM_SRC*DATA_W, flattened sources; source i occupies [i*DATA_W +: DATA_W].
- sel, input, SEL_W, bus select code; 0 selects the zero bus.
- sel_valid, input, 1, select request valid.
- sel_ready, output, 1, buffer can accept a select.
- b_bus, output, DATA_W, registered bus value (head of buffer).
- b_valid, output, 1, b_bus holds valid data.
- b_ready, input, 1, consumer accepts b_bus.
- err_sel, output, 1, sticky illegal-select flag.
- err_clr, input, 1, clears err_sel.
- xfer_cnt, output, CNT_W, number of completed output transfers.

Behaviour:
- Reset (async assert, sync release): b_bus=0, b_valid=0, sel_ready=1, err_sel=0, xfer_cnt=0, skid entry empty.
- Accept: accept = sel_valid & sel_ready. The value is computed combinationally from src_data/sel in the accepting cycle and snapshotted. Later src_data changes do not affect the stored value.
- Value rules:
  - sel=0 gives 0.
  - sel=k in 1..NUM_SRC gives source k-1, zero-extended if narrow. Upper bits of a narrow source are ignored.
  - sel>NUM_SRC gives 0, and err_sel is set on accept.
- Drain: drain = b_valid & b_ready. xfer_cnt increments on each drain and wraps modulo 2**CNT_W.
- Latency: accept in cycle N gives b_valid=1 with the value in cycle N+1 if the buffer was empty.
- Occupancy states are EMPTY (0), ONE (1) and FULL (2). sel_ready is registered and equals (state!=FULL).
- Transitions:
  - EMPTY + accept -> ONE; main <= value.
  - ONE + accept & !drain -> FULL; skid <= value, main holds.
  - ONE + drain & !accept -> EMPTY.
  - ONE + accept & drain -> ONE; main <= new value.
  - FULL + drain -> ONE; main <= skid. No accept is possible because sel_ready=0.
  - All other combinations hold state.
- Ordering: strictly FIFO. b_bus and b_valid are stable while b_valid=1 and b_ready=0.
- err_sel: set on an accepted illegal select. err_clr clears it. If both happen in the same cycle, set wins.
- Non-accepted illegal selects (sel_ready=0 or sel_valid=0) do not set err_sel.
- Reset mid-operation: buffered entries are discarded immediately. xfer_cnt and err_sel are cleared.
- No combinational path from b_ready to sel_ready.

Decomposition:
- Package b_bus_pkg holds:
  - select-code constants: SEL_ZERO=0, SEL_MDR=1, SEL_PC=2, SEL_MBRU=3, SEL_L=4, SEL_C1=5, SEL_C2=6, SEL_C3=7, SEL_T=8, SEL_E=9;
  - the occupancy state localparams EMPTY/ONE/FULL;
  - default width constants.
- Sub-module b_bus_skid_buf: a generic 2-entry valid/ready skid buffer with WIDTH parameter, occupancy FSM and registered in_ready.
- The top level contains the combinational select/zero-extend logic, the error flag and the transfer counter.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, sel_valid=0 -> b_valid=0, sel_ready=1, b_bus=0, xfer_cnt=0, err_sel=0.
- Narrow zero-extend: MDR=24'hABCD5A, sel=1, sel_valid=1, b_ready=1 -> next cycle b_bus=24'h00005A, b_valid=1; xfer_cnt=1 after drain.
- Stall and fill: b_ready=0, issue sel=4 (L=24'h123456) then sel=9 (E=24'h00FFEE) -> sel_ready=0 after the 2nd accept. A 3rd request is held with no accept. Raise b_ready -> outputs 24'h123456 then 24'h00FFEE, and sel_ready returns to 1.
- Snapshot: accept sel=5 with C1=24'h111111, change C1 to 24'h222222 while stalled -> b_bus stays 24'h111111.
- Illegal select: sel=4'hF accepted -> b_bus=0, err_sel=1 and it persists. err_clr together with a new illegal accept -> err_sel remains 1. err_clr alone -> 0.
- Counter wrap and async reset: CNT_W=4, 17 back-to-back transfers -> xfer_cnt=1. Assert rst_n low mid-stream with the buffer FULL -> b_valid=0 and sel_ready=1 immediately, without waiting for a clock edge.
